// File: rtl/mono_video_mapper.sv
// ---------------------------------------------------------------------------
// mono_video_mapper
//
// Monochrome video back end for single-bit-per-plane arcade cores. Generates
// a pixel clock-enable from clk_sys, maps an LVL_W-bit level code through a
// runtime-writable luminance palette, applies invert and dim, delay-matches
// blank/sync to the luminance path and counts frames.
//
// Parameters:
//   LVL_W     width of the level code (palette has 2**LVL_W entries)
//   OUT_W     luminance output width
//   DIV       clk_sys cycles per pixel (1..256)
//   PAL_INIT  packed reset palette, entry k at [k*OUT_W +: OUT_W]
//
// Ports:
//   clk_sys                          in   system/video clock (only clock)
//   reset_n                          in   asynchronous active-low reset
//   level_in[LVL_W]                  in   raw level code from the core
//   hblank_in/vblank_in/hs_in/vs_in  in   raw timing from the core
//   pal_wr, pal_addr, pal_data       in   palette write port, any clk_sys edge
//   invert, dim                      in   output modes, sampled at stage 2
//   ce_pix                           out  one-clock pixel enable every DIV clocks
//   luma_out[OUT_W]                  out  mapped luminance (0 during blank)
//   hblank_out/vblank_out/hs_out/vs_out out timing aligned with luma_out
//   frame_cnt[16]                    out  count of vblank_out rising edges
// ---------------------------------------------------------------------------
module mono_video_mapper #(
    parameter int unsigned                  LVL_W    = 2,
    parameter int unsigned                  OUT_W    = 8,
    parameter int unsigned                  DIV      = 8,
    parameter logic [(2**LVL_W)*OUT_W-1:0]  PAL_INIT = {8'hFF, 8'h86, 8'h50, 8'h00}
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [LVL_W-1:0] level_in,
    input  logic             hblank_in,
    input  logic             vblank_in,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic             pal_wr,
    input  logic [LVL_W-1:0] pal_addr,
    input  logic [OUT_W-1:0] pal_data,
    input  logic             invert,
    input  logic             dim,
    output logic             ce_pix,
    output logic [OUT_W-1:0] luma_out,
    output logic             hblank_out,
    output logic             vblank_out,
    output logic             hs_out,
    output logic             vs_out,
    output logic [15:0]      frame_cnt
);

    localparam int unsigned      NUM_ENT  = 2**LVL_W;
    localparam int unsigned      CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

    // Pixel divider
    logic [CNT_W-1:0] r_div_cnt;
    logic             r_ce_pix;

    // Stage 1: raw inputs captured on ce_pix
    logic [LVL_W-1:0] r_s1_level;
    logic             r_s1_hblank;
    logic             r_s1_vblank;
    logic             r_s1_hs;
    logic             r_s1_vs;

    // Palette
    logic [OUT_W-1:0] r_pal [NUM_ENT];

    // Stage 2: outputs
    logic [OUT_W-1:0] r_luma;
    logic             r_hblank_out;
    logic             r_vblank_out;
    logic             r_hs_out;
    logic             r_vs_out;
    logic [15:0]      r_frame_cnt;

    // Stage 2 combinational path
    logic [OUT_W-1:0] w_entry;
    logic [OUT_W-1:0] w_inv;
    logic [OUT_W-1:0] w_dim;
    logic [OUT_W-1:0] w_luma_nxt;
    logic             w_frame_rise;

    // ------------------------------------------------------------------
    // Divider: ce_pix is registered from the terminal count, so the first
    // pulse appears on the DIV-th edge after reset and lasts one clock.
    // With DIV=1 the counter sits at 0 and ce_pix stays high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_ce_pix  <= 1'b0;
        end else begin
            r_ce_pix <= (r_div_cnt == DIV_LAST);
            if (r_div_cnt == DIV_LAST) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_level  <= '0;
            r_s1_hblank <= 1'b0;
            r_s1_vblank <= 1'b0;
            r_s1_hs     <= 1'b0;
            r_s1_vs     <= 1'b0;
        end else if (r_ce_pix) begin
            r_s1_level  <= level_in;
            r_s1_hblank <= hblank_in;
            r_s1_vblank <= vblank_in;
            r_s1_hs     <= hs_in;
            r_s1_vs     <= vs_in;
        end
    end

    // ------------------------------------------------------------------
    // Palette: written on any edge, independent of ce_pix. A lookup on the
    // same edge reads the pre-write value since both use registered state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                r_pal[i] <= PAL_INIT[i*OUT_W +: OUT_W];
            end
        end else if (pal_wr) begin
            r_pal[pal_addr] <= pal_data;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 mapping: palette, then invert, then dim; blank forces zero
    // so modes never leak into the blanking interval.
    // ------------------------------------------------------------------
    always_comb begin
        w_entry      = r_pal[r_s1_level];
        w_inv        = invert ? ~w_entry : w_entry;
        w_dim        = dim ? (w_inv >> 1) : w_inv;
        w_luma_nxt   = (r_s1_hblank | r_s1_vblank) ? '0 : w_dim;
        // Rising edge of vblank_out as it will be after this ce_pix
        w_frame_rise = r_s1_vblank & ~r_vblank_out;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_luma       <= '0;
            r_hblank_out <= 1'b0;
            r_vblank_out <= 1'b0;
            r_hs_out     <= 1'b0;
            r_vs_out     <= 1'b0;
        end else if (r_ce_pix) begin
            r_luma       <= w_luma_nxt;
            r_hblank_out <= r_s1_hblank;
            r_vblank_out <= r_s1_vblank;
            r_hs_out     <= r_s1_hs;
            r_vs_out     <= r_s1_vs;
        end
    end

    // ------------------------------------------------------------------
    // Frame counter, updated on the same edge that vblank_out rises.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= '0;
        end else if (r_ce_pix && w_frame_rise) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign ce_pix     = r_ce_pix;
    assign luma_out   = r_luma;
    assign hblank_out = r_hblank_out;
    assign vblank_out = r_vblank_out;
    assign hs_out     = r_hs_out;
    assign vs_out     = r_vs_out;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_mono_video_mapper.sv
// ---------------------------------------------------------------------------
// Testbench for mono_video_mapper. Main instance uses DIV=8 and the default
// palette; a second DIV=1 instance exercises asynchronous mid-line reset.
// Expected values come from a pixel-level model: each output pixel is the
// previous pixel's inputs mapped through the model palette with the modes
// present at the moment it is emitted.
// ---------------------------------------------------------------------------
module tb_mono_video_mapper;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Main DUT (DIV=8)
    logic        reset_n;
    logic [1:0]  level_in;
    logic        hblank_in, vblank_in, hs_in, vs_in;
    logic        pal_wr;
    logic [1:0]  pal_addr;
    logic [7:0]  pal_data;
    logic        invert, dim;
    logic        ce_pix;
    logic [7:0]  luma_out;
    logic        hblank_out, vblank_out, hs_out, vs_out;
    logic [15:0] frame_cnt;

    // Second DUT (DIV=1)
    logic        rst1_n;
    logic [1:0]  lvl1;
    logic        pal_wr1;
    logic [1:0]  pal_addr1;
    logic [7:0]  pal_data1;
    logic        z0;
    logic        ce1;
    logic [7:0]  luma1;
    logic        hb1, vb1, hs1, vs1;
    logic [15:0] frame1;

    int n_tests = 0;
    int n_fail  = 0;

    mono_video_mapper #(.LVL_W(2), .OUT_W(8), .DIV(8)) u_dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .level_in   (level_in),
        .hblank_in  (hblank_in),
        .vblank_in  (vblank_in),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .pal_wr     (pal_wr),
        .pal_addr   (pal_addr),
        .pal_data   (pal_data),
        .invert     (invert),
        .dim        (dim),
        .ce_pix     (ce_pix),
        .luma_out   (luma_out),
        .hblank_out (hblank_out),
        .vblank_out (vblank_out),
        .hs_out     (hs_out),
        .vs_out     (vs_out),
        .frame_cnt  (frame_cnt)
    );

    mono_video_mapper #(.LVL_W(2), .OUT_W(8), .DIV(1)) u_dut1 (
        .clk_sys    (clk_sys),
        .reset_n    (rst1_n),
        .level_in   (lvl1),
        .hblank_in  (z0),
        .vblank_in  (z0),
        .hs_in      (z0),
        .vs_in      (z0),
        .pal_wr     (pal_wr1),
        .pal_addr   (pal_addr1),
        .pal_data   (pal_data1),
        .invert     (z0),
        .dim        (z0),
        .ce_pix     (ce1),
        .luma_out   (luma1),
        .hblank_out (hb1),
        .vblank_out (vb1),
        .hs_out     (hs1),
        .vs_out     (vs1),
        .frame_cnt  (frame1)
    );

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    logic [7:0]  m_pal [4];
    logic [1:0]  p_lvl;
    logic        p_hb, p_vb, p_hs, p_vs;
    logic        m_vb_out;
    logic [15:0] m_frame;

    task automatic model_reset();
        m_pal[0] = 8'h00;
        m_pal[1] = 8'h50;
        m_pal[2] = 8'h86;
        m_pal[3] = 8'hFF;
        p_lvl = 2'd0; p_hb = 1'b0; p_vb = 1'b0; p_hs = 1'b0; p_vs = 1'b0;
        m_vb_out = 1'b0;
        m_frame  = 16'd0;
    endtask

    // Wait (bounded) until the cycle in which ce_pix is high, at a negedge.
    task automatic wait_ce();
        int k;
        k = 0;
        @(negedge clk_sys);
        while (ce_pix !== 1'b1 && k < 20) begin
            @(negedge clk_sys);
            k++;
        end
        n_tests++;
        if (ce_pix !== 1'b1) begin
            n_fail++;
            $display("FAIL ce_timeout: ce_pix=%b after %0d cycles, required 1", ce_pix, k);
        end
    endtask

    // Present one pixel on the inputs just before a ce_pix edge and return
    // what the outputs must show after that edge.
    task automatic drive_pixel(
        input  logic [1:0]  lvl,
        input  logic        hb, vb, hs, vs, inv, dm, wr,
        input  logic [1:0]  waddr,
        input  logic [7:0]  wdata,
        output logic [7:0]  e_luma,
        output logic        e_hb, e_vb, e_hs, e_vs,
        output logic [15:0] e_frame
    );
        logic [7:0] e;
        wait_ce();
        level_in = lvl; hblank_in = hb; vblank_in = vb; hs_in = hs; vs_in = vs;
        invert = inv; dim = dm;
        pal_wr = wr; pal_addr = waddr; pal_data = wdata;
        e = m_pal[p_lvl];
        if (inv) e = ~e;
        if (dm)  e = e >> 1;
        e_luma = (p_hb || p_vb) ? 8'h00 : e;
        e_hb = p_hb; e_vb = p_vb; e_hs = p_hs; e_vs = p_vs;
        if (p_vb && !m_vb_out) m_frame = m_frame + 16'd1;
        m_vb_out = p_vb;
        e_frame  = m_frame;
        if (wr) m_pal[waddr] = wdata;
        p_lvl = lvl; p_hb = hb; p_vb = vb; p_hs = hs; p_vs = vs;
        @(posedge clk_sys);
        #1;
        pal_wr = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0; rst1_n = 1'b0;
        repeat (5) @(posedge clk_sys);
        @(negedge clk_sys);
        n_tests++;
        if ({ce_pix, luma_out, hblank_out, vblank_out, hs_out, vs_out, frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ce=%b luma=%h hb=%b vb=%b hs=%b vs=%b fc=%h, required all 0",
                     ce_pix, luma_out, hblank_out, vblank_out, hs_out, vs_out, frame_cnt);
        end
        model_reset();
        reset_n = 1'b1; rst1_n = 1'b1;
    endtask

    task automatic test_ce_timing();
        logic req;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk_sys);
            #1;
            req = (k % 8 == 0);
            n_tests++;
            if (ce_pix !== req) begin
                n_fail++;
                $display("FAIL ce_pix_edge%0d: got %b, required %b", k, ce_pix, req);
            end
        end
    endtask

    task automatic test_levels();
        logic [7:0]  tab [4];
        logic [7:0]  el;
        logic        ehb, evb, ehs, evs;
        logic [15:0] ef;
        logic [1:0]  prev;
        tab[0] = 8'h00; tab[1] = 8'h50; tab[2] = 8'h86; tab[3] = 8'hFF;
        for (int i = 0; i <= 4; i++) begin
            drive_pixel(2'(i % 4), 1'b0, 1'b0, i[0], i[1], 1'b0, 1'b0, 1'b0, 2'd0, 8'h00,
                        el, ehb, evb, ehs, evs, ef);
            if (i >= 1) begin
                prev = 2'(i - 1);
                n_tests++;
                if (luma_out !== tab[prev]) begin
                    n_fail++;
                    $display("FAIL level_map%0d: luma=%h, required %h", i - 1, luma_out, tab[prev]);
                end
                n_tests++;
                if ({hs_out, vs_out} !== {prev[0], prev[1]}) begin
                    n_fail++;
                    $display("FAIL sync_align%0d: hs/vs=%b%b, required %b%b",
                             i - 1, hs_out, vs_out, prev[0], prev[1]);
                end
            end
        end
    endtask

    task automatic test_modes();
        logic [7:0]  el;
        logic        ehb, evb, ehs, evs;
        logic [15:0] ef;
        drive_pixel(2'd3, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'h00, el, ehb, evb, ehs, evs, ef);
        drive_pixel(2'd2, 0, 0, 0, 0, 1, 0, 0, 2'd0, 8'h00, el, ehb, evb, ehs, evs, ef);
        n_tests++;
        if (luma_out !== 8'h00) begin
            n_fail++;
            $display("FAIL invert_l3: luma=%h, required 00", luma_out);
        end
        drive_pixel(2'd3, 1, 0, 0, 0, 1, 1, 0, 2'd0, 8'h00, el, ehb, evb, ehs, evs, ef);
        n_tests++;
        if (luma_out !== 8'h3C) begin
            n_fail++;
            $display("FAIL invert_dim_l2: luma=%h, required 3c", luma_out);
        end
        drive_pixel(2'd0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 8'h00, el, ehb, evb, ehs, evs, ef);
        n_tests++;
        if (luma_out !== 8'h00 || hblank_out !== 1'b1) begin
            n_fail++;
            $display("FAIL hblank_l3: luma=%h hb=%b, required 00 1", luma_out, hblank_out);
        end
    endtask

    task automatic test_pal_collision();
        logic [7:0]  el;
        logic        ehb, evb, ehs, evs;
        logic [15:0] ef;
        drive_pixel(2'd1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'h00, el, ehb, evb, ehs, evs, ef);
        drive_pixel(2'd1, 0, 0, 0, 0, 0, 0, 1, 2'd1, 8'hA5, el, ehb, evb, ehs, evs, ef);
        n_tests++;
        if (luma_out !== 8'h50) begin
            n_fail++;
            $display("FAIL pal_collision_old: luma=%h, required 50", luma_out);
        end
        drive_pixel(2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'h00, el, ehb, evb, ehs, evs, ef);
        n_tests++;
        if (luma_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL pal_collision_new: luma=%h, required a5", luma_out);
        end
    endtask

    task automatic test_frames();
        logic [7:0]  el;
        logic        ehb, evb, ehs, evs;
        logic [15:0] ef;
        logic        vbs [7];
        logic [15:0] fcs [7];
        vbs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        fcs = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3};
        for (int i = 0; i < 7; i++) begin
            drive_pixel(2'd2, 0, vbs[i], 0, 0, 0, 0, 0, 2'd0, 8'h00, el, ehb, evb, ehs, evs, ef);
            n_tests++;
            if (frame_cnt !== fcs[i]) begin
                n_fail++;
                $display("FAIL frame_cnt_step%0d: got %0d, required %0d", i, frame_cnt, fcs[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0]  el;
        logic        ehb, evb, ehs, evs;
        logic [15:0] ef;
        for (int i = 0; i < 60; i++) begin
            drive_pixel(2'($urandom_range(0, 3)),
                        ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                        1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                        ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)), 8'($urandom),
                        el, ehb, evb, ehs, evs, ef);
            n_tests++;
            if (luma_out !== el) begin
                n_fail++;
                $display("FAIL rand_luma%0d: got %h, required %h", i, luma_out, el);
            end
            n_tests++;
            if ({hblank_out, vblank_out, hs_out, vs_out} !== {ehb, evb, ehs, evs}) begin
                n_fail++;
                $display("FAIL rand_timing%0d: got %b%b%b%b, required %b%b%b%b", i,
                         hblank_out, vblank_out, hs_out, vs_out, ehb, evb, ehs, evs);
            end
            n_tests++;
            if (frame_cnt !== ef) begin
                n_fail++;
                $display("FAIL rand_frame%0d: got %0d, required %0d", i, frame_cnt, ef);
            end
            // Outputs must hold between pixel enables
            repeat (3) @(negedge clk_sys);
            n_tests++;
            if (luma_out !== el) begin
                n_fail++;
                $display("FAIL rand_hold%0d: got %h, required %h", i, luma_out, el);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk_sys);
        lvl1 = 2'd3; pal_wr1 = 1'b1; pal_addr1 = 2'd3; pal_data1 = 8'h12;
        @(negedge clk_sys);
        pal_wr1 = 1'b0;
        @(posedge clk_sys);
        #1;
        n_tests++;
        if (luma1 !== 8'h12) begin
            n_fail++;
            $display("FAIL div1_written: luma=%h, required 12", luma1);
        end
        @(negedge clk_sys);
        rst1_n = 1'b0;
        #1;
        n_tests++;
        if ({ce1, luma1, hb1, vb1, hs1, vs1, frame1} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: ce=%b luma=%h fc=%h, required all 0", ce1, luma1, frame1);
        end
        @(negedge clk_sys);
        rst1_n = 1'b1;
        @(posedge clk_sys);
        #1;
        n_tests++;
        if (ce1 !== 1'b1 || luma1 !== 8'h00) begin
            n_fail++;
            $display("FAIL div1_resume: ce=%b luma=%h, required 1 00", ce1, luma1);
        end
        repeat (2) @(posedge clk_sys);
        #1;
        n_tests++;
        if (luma1 !== 8'hFF) begin
            n_fail++;
            $display("FAIL pal_reload: luma=%h, required ff", luma1);
        end
    endtask

    initial begin
        level_in = '0; hblank_in = 0; vblank_in = 0; hs_in = 0; vs_in = 0;
        pal_wr = 0; pal_addr = '0; pal_data = '0; invert = 0; dim = 0;
        lvl1 = '0; pal_wr1 = 0; pal_addr1 = '0; pal_data1 = '0; z0 = 1'b0;
        reset_n = 1'b0; rst1_n = 1'b0;
        model_reset();
        test_reset();
        test_ce_timing();
        test_levels();
        test_modes();
        test_pal_collision();
        test_frames();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

endmodule
